pipe_stage_hs: RTL



---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_sat_counter.sv | 13 +
 rtl/pipe_stage_hs.sv | 79 +++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, control-bit indices and default widths
// for the pipeline stage register.
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
  localparam int CTRL_WREG   = 0;
  localparam int CTRL_WMEM   = 1;
  localparam int CTRL_RMEM   = 2;
  localparam int CTRL_ALUIMM = 3;
  localparam int CTRL_SHIFT  = 4;
  localparam int CTRL_JAL    = 5;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_CTRL_W  = 8;
  localparam int DEF_CNT_W   = 16;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: up-counter that sticks at its all-ones value.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_0,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clock)
    if (!reset_0) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline stage register with optional 2-entry skid,
// synchronous flush to a control-clean bubble, and stall/bubble counters.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset_0,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  state_t state, next;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic ready_q, accept, emit, ld_in, ld_from_skid, ld_skid;
  assign out_valid = state != EMPTY;
  assign in_ready  = SKID ? ready_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  // Without a skid, FULL never sees accept-without-emit because in_ready is low then.
  always_comb begin
    next = state;
    ld_in = 1'b0;
    ld_from_skid = 1'b0;
    ld_skid = 1'b0;
    case (state)
      EMPTY: begin
        next = accept ? FULL : EMPTY;
        ld_in = accept;
      end
      FULL: begin
        next = emit ? (accept ? FULL : EMPTY) : (accept ? pipe_pkg::SKID : FULL);
        ld_in = emit && accept;
        ld_skid = !emit && accept;
      end
      default: begin
        next = emit ? FULL : state;
        ld_from_skid = emit;
      end
    endcase
    if (flush) next = EMPTY;
  end
  always_ff @(posedge clock)
    if (!reset_0) begin
      state <= EMPTY;
      ready_q <= 1'b1;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= next;
      ready_q <= next != pipe_pkg::SKID;
      if (ld_in) {main_ctrl, main_data} <= {in_ctrl, in_data};
      else if (ld_from_skid) {main_ctrl, main_data} <= {skid_ctrl, skid_data};
      if (ld_skid) {skid_ctrl, skid_data} <= {in_ctrl, in_data};
    end
  pipe_sat_counter #(.W(CNT_W)) u_stall (
    .clock(clock), .reset_0(reset_0), .inc(out_valid && !out_ready), .count(stall_cnt)
  );
  pipe_sat_counter #(.W(CNT_W)) u_bubble (
    .clock(clock), .reset_0(reset_0), .inc(!out_valid && out_ready), .count(bubble_cnt)
  );
endmodule
